einstein_kbd_matrix: RTL and testbench
======================================

# einstein_kbd_matrix

Converts MiSTer `ps2_key` events into the Einstein 8×8 keyboard matrix plus the SHIFT/CTRL/GRAPH lines. It feeds `kb_col`, `kb_shift`, `kb_ctrl` and `kb_graph` of the `tatung` core. The core's PSG port A drives `kb_row`; this block returns the matching column pattern. A per-key release stretcher keeps short taps visible to the firmware's polling and keyboard-interrupt logic.

## Interface
Parameters:
- `TICK_CYCLES`, 32000: `clk_sys` cycles per stretch tick (1 ms at 32 MHz); minimum 2.

Ports:
- `clk_sys`: input, 1. System clock, 32 MHz.
- `reset`: input, 1. Asynchronous, active-high.
- `ps2_key`: input, 11. [10] toggle per event, [9] pressed, [8] E0-extended, [7:0] set-2 scancode.
- `kb_row`: input, 8. Active-low row select from PSG IOA; more than one row may be low.
- `kb_col`: output, 8. Active-low columns; bit c = 0 when any selected row has key (r,c) down.
- `kb_shift`: output, 1. Active-low; either shift key held.
- `kb_ctrl`: output, 1. Active-low; either Ctrl key held.
- `kb_graph`: output, 1. Active-low; either Alt key held.
- `key_valid`: output, 1. One-cycle pulse when an accepted event hit a matrix key or modifier (debug/verification).

## Operation
- Event detect: a new event is `ps2_key[10]` differing from its registered copy. The registered copy resets to 0, so a toggle already at 1 out of reset is taken as one event.
- Decode:
  - `{ps2_key[8], ps2_key[7:0]}` goes through the keymap to `{hit, mod, row[2:0], col[2:0]}`.
  - Unmapped codes are ignored: no state change, no `key_valid`.
- Modifier keys:
  - Separate flags for LShift 0x12, RShift 0x59, LCtrl 0x14, RCtrl E0 14, LAlt 0x11, RAlt E0 11.
  - Each flag is set on press and cleared on release.
  - Modifiers are not stretched.
  - `kb_shift = ~(lsh | rsh)`. Ctrl and Graph are built the same way.
- Matrix state per key (r,c): `down`, `pend1`, `pend2`.
  - Press: `down=1`, `pend1=0`, `pend2=0`.
  - Release: `pend1=1`. `down` stays 1.
  - On a tick, for every key in parallel: `pend2 <= pend1`, `pend1 <= 0`. If `pend2` was 1, then `down <= 0` and `pend2 <= 0`.
  - Net effect: a released key stays visible for at least `TICK_CYCLES` and fewer than `2*TICK_CYCLES` cycles.
- Tick: a free-running counter 0..`TICK_CYCLES-1`. It pulses at wrap, one cycle per period.
- Simultaneous event and tick on the same key: the event wins. A press clears the pend bits. A release sets `pend1` and leaves `pend2` and `down` unchanged this cycle.
- Repeated press (typematic) while already down: no change besides clearing pend bits. It still pulses `key_valid`.
- Column output: `kb_col[c] = ~|(down[r][c] & ~kb_row[r])` over r, registered once.
- Reset (any time, including mid-event):
  - All `down`/`pend` bits and modifier flags go to 0.
  - Tick counter and toggle copy go to 0.
  - `kb_col=8'hFF`, `kb_shift=kb_ctrl=kb_graph=1`, `key_valid=0`.

## Timing
- Event to internal state: 1 cycle after the toggle edge is sampled.
- `kb_row` change to `kb_col`: 1 cycle (registered). The firmware reads through PSG at 2 MHz, so this latency is invisible.
- Event to `kb_col`: 2 cycles, provided the key's row is selected.
- Modifier outputs: registered, 2 cycles after the event.
- `key_valid`: asserted in the cycle the state updates.
- Events arriving every cycle are each accepted; there is no back-pressure.

## Structure
- Package `einstein_kbd_pkg`:
  - `TICK_CYCLES` default.
  - Keymap entry typedef `{hit, mod, row, col}`.
  - Modifier scancode constants.
  - The 512-entry keymap function.
- Fixed keymap entries used by the test plan:
  - 0x1C 'A' → (row 2, col 1).
  - 0x29 Space → (row 7, col 0).
  - 0x5A Return → (row 0, col 7).
  - E0 75 Up → (row 5, col 3).
- Sub-module `einstein_keymap`: combinational lookup wrapping the package function. It is the only instance.

## Test plan
- Reset, then press 0x1C with `kb_row=8'hFB` → `kb_col=8'hFD` two cycles later. With `kb_row=8'hFF` → `kb_col=8'hFF`.
- Press then release 0x29 one cycle apart, `kb_row=8'h7F`, `TICK_CYCLES=100`:
  - `kb_col[0]=0` for at least 100 and fewer than 200 cycles after the release.
  - Then `kb_col=8'hFF`.
- Press LShift and RShift, release LShift → `kb_shift` stays 0. Release RShift → `kb_shift=1` two cycles later.
- Press E0 75 and 0x5A, `kb_row=8'hDE` → `kb_col=8'h77`. Plain 0x75 (unmapped) → no change, `key_valid=0`.
- Release 0x1C on the exact cycle of a tick with `pend2` set from an earlier release → key is still down afterwards.
- Press 0x1C and 0x12, assert `reset` for 1 cycle mid-hold → `kb_col=8'hFF` and `kb_shift=1` immediately, and they stay so after reset.

Source files
------------

// File: rtl/einstein_kbd_matrix_pkg.sv
// Shared types and constants for the Einstein keyboard matrix, including the
// PS/2 set-2 (E0 flag + scancode) to matrix position keymap.
package einstein_kbd_pkg;

    localparam int unsigned TICK_CYCLES_DEFAULT = 32000;

    typedef struct packed {
        logic       hit;
        logic       mod;
        logic [2:0] row;
        logic [2:0] col;
    } keymap_entry_t;

    typedef enum logic [2:0] {
        MOD_LSHIFT = 3'd0,
        MOD_RSHIFT = 3'd1,
        MOD_LCTRL  = 3'd2,
        MOD_RCTRL  = 3'd3,
        MOD_LALT   = 3'd4,
        MOD_RALT   = 3'd5
    } mod_idx_e;

    localparam logic [8:0] SC_LSHIFT = 9'h012;
    localparam logic [8:0] SC_RSHIFT = 9'h059;
    localparam logic [8:0] SC_LCTRL  = 9'h014;
    localparam logic [8:0] SC_RCTRL  = 9'h114;
    localparam logic [8:0] SC_LALT   = 9'h011;
    localparam logic [8:0] SC_RALT   = 9'h111;

    function automatic keymap_entry_t key_at(input logic [2:0] r, input logic [2:0] c);
        key_at = '{hit: 1'b1, mod: 1'b0, row: r, col: c};
    endfunction

    // Modifier entries carry the modifier flag index in the col field.
    function automatic keymap_entry_t mod_at(input mod_idx_e m);
        mod_at = '{hit: 1'b1, mod: 1'b1, row: 3'd0, col: m};
    endfunction

    function automatic keymap_entry_t keymap_lookup(input logic [8:0] code);
        keymap_entry_t e;
        case (code)
            SC_LSHIFT: e = mod_at(MOD_LSHIFT);
            SC_RSHIFT: e = mod_at(MOD_RSHIFT);
            SC_LCTRL:  e = mod_at(MOD_LCTRL);
            SC_RCTRL:  e = mod_at(MOD_RCTRL);
            SC_LALT:   e = mod_at(MOD_LALT);
            SC_RALT:   e = mod_at(MOD_RALT);
            9'h066: e = key_at(3'd0, 3'd0);
            9'h00D: e = key_at(3'd0, 3'd1);
            9'h076: e = key_at(3'd0, 3'd2);
            9'h05A: e = key_at(3'd0, 3'd7);
            9'h045: e = key_at(3'd1, 3'd0);
            9'h016: e = key_at(3'd1, 3'd1);
            9'h01E: e = key_at(3'd1, 3'd2);
            9'h026: e = key_at(3'd1, 3'd3);
            9'h025: e = key_at(3'd1, 3'd4);
            9'h02E: e = key_at(3'd1, 3'd5);
            9'h036: e = key_at(3'd1, 3'd6);
            9'h03D: e = key_at(3'd1, 3'd7);
            9'h01C: e = key_at(3'd2, 3'd1);
            9'h032: e = key_at(3'd2, 3'd2);
            9'h021: e = key_at(3'd2, 3'd3);
            9'h023: e = key_at(3'd2, 3'd4);
            9'h024: e = key_at(3'd2, 3'd5);
            9'h02B: e = key_at(3'd2, 3'd6);
            9'h034: e = key_at(3'd2, 3'd7);
            9'h033: e = key_at(3'd3, 3'd0);
            9'h043: e = key_at(3'd3, 3'd1);
            9'h03B: e = key_at(3'd3, 3'd2);
            9'h042: e = key_at(3'd3, 3'd3);
            9'h04B: e = key_at(3'd3, 3'd4);
            9'h03A: e = key_at(3'd3, 3'd5);
            9'h031: e = key_at(3'd3, 3'd6);
            9'h044: e = key_at(3'd3, 3'd7);
            9'h04D: e = key_at(3'd4, 3'd0);
            9'h015: e = key_at(3'd4, 3'd1);
            9'h02D: e = key_at(3'd4, 3'd2);
            9'h01B: e = key_at(3'd4, 3'd3);
            9'h02C: e = key_at(3'd4, 3'd4);
            9'h03C: e = key_at(3'd4, 3'd5);
            9'h02A: e = key_at(3'd4, 3'd6);
            9'h01D: e = key_at(3'd4, 3'd7);
            9'h022: e = key_at(3'd5, 3'd0);
            9'h035: e = key_at(3'd5, 3'd1);
            9'h01A: e = key_at(3'd5, 3'd2);
            9'h175: e = key_at(3'd5, 3'd3);
            9'h172: e = key_at(3'd5, 3'd4);
            9'h16B: e = key_at(3'd5, 3'd5);
            9'h174: e = key_at(3'd5, 3'd6);
            9'h029: e = key_at(3'd7, 3'd0);
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/einstein_kbd_matrix_if.sv
// Keyboard-side signal bundle: PS/2 events and row select in, matrix lines out.
interface einstein_kbd_matrix_if;

    logic [10:0] ps2_key;
    logic [7:0]  kb_row;
    logic [7:0]  kb_col;
    logic        kb_shift;
    logic        kb_ctrl;
    logic        kb_graph;
    logic        key_valid;

    modport master (
        output ps2_key, kb_row,
        input  kb_col, kb_shift, kb_ctrl, kb_graph, key_valid
    );

    modport slave (
        input  ps2_key, kb_row,
        output kb_col, kb_shift, kb_ctrl, kb_graph, key_valid
    );

endinterface

// File: rtl/einstein_kbd_matrix_keymap.sv
// Combinational keymap lookup: {E0, scancode} to matrix position or modifier.
module einstein_keymap
    import einstein_kbd_pkg::*;
(
    input  logic [8:0]    i_code,
    output keymap_entry_t o_entry
);

    assign o_entry = keymap_lookup(i_code);

endmodule

// File: rtl/einstein_kbd_matrix.sv
// PS/2 event to Einstein 8x8 keyboard matrix with per-key release stretching
// and SHIFT/CTRL/GRAPH modifier lines.
module einstein_kbd_matrix
    import einstein_kbd_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  kb_row,
    output logic [7:0]  kb_col,
    output logic        kb_shift,
    output logic        kb_ctrl,
    output logic        kb_graph,
    output logic        key_valid
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic                  r_toggle;
    logic [CNT_W-1:0]      r_tick_cnt;
    logic [7:0][7:0]       r_down, r_pend1, r_pend2;
    logic [5:0]            r_mod;
    logic [7:0]            r_col;
    logic                  r_shift, r_ctrl, r_graph, r_key_valid;

    keymap_entry_t         w_entry;
    logic                  w_accept, w_tick;
    logic [7:0][7:0]       w_down_nx, w_pend1_nx, w_pend2_nx;
    logic [7:0]            w_col_nx;

    einstein_keymap u_keymap (
        .i_code  (ps2_key[8:0]),
        .o_entry (w_entry)
    );

    assign w_accept = (ps2_key[10] ^ r_toggle) & w_entry.hit;
    assign w_tick   = (r_tick_cnt == CNT_W'(TICK_CYCLES - 1));

    // Tick ages every key first; an event on the same key then overrides that key.
    always_comb begin
        w_down_nx  = r_down;
        w_pend1_nx = r_pend1;
        w_pend2_nx = r_pend2;
        if (w_tick) begin
            w_down_nx  = r_down & ~r_pend2;
            w_pend2_nx = r_pend1 & ~r_pend2;
            w_pend1_nx = '0;
        end
        if (w_accept && !w_entry.mod) begin
            if (ps2_key[9]) begin
                w_down_nx[w_entry.row][w_entry.col]  = 1'b1;
                w_pend1_nx[w_entry.row][w_entry.col] = 1'b0;
                w_pend2_nx[w_entry.row][w_entry.col] = 1'b0;
            end else begin
                w_down_nx[w_entry.row][w_entry.col]  = r_down[w_entry.row][w_entry.col];
                w_pend1_nx[w_entry.row][w_entry.col] = 1'b1;
                w_pend2_nx[w_entry.row][w_entry.col] = r_pend2[w_entry.row][w_entry.col];
            end
        end
    end

    for (genvar gc = 0; gc < 8; gc++) begin : g_col
        logic [7:0] w_hits;
        for (genvar gr = 0; gr < 8; gr++) begin : g_row
            assign w_hits[gr] = r_down[gr][gc] & ~kb_row[gr];
        end
        assign w_col_nx[gc] = ~|w_hits;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_toggle    <= 1'b0;
            r_tick_cnt  <= '0;
            r_down      <= '0;
            r_pend1     <= '0;
            r_pend2     <= '0;
            r_mod       <= '0;
            r_col       <= '1;
            r_shift     <= 1'b1;
            r_ctrl      <= 1'b1;
            r_graph     <= 1'b1;
            r_key_valid <= 1'b0;
        end else begin
            r_toggle    <= ps2_key[10];
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_down      <= w_down_nx;
            r_pend1     <= w_pend1_nx;
            r_pend2     <= w_pend2_nx;
            if (w_accept && w_entry.mod) begin
                r_mod[w_entry.col] <= ps2_key[9];
            end
            r_col       <= w_col_nx;
            r_shift     <= ~(r_mod[MOD_LSHIFT] | r_mod[MOD_RSHIFT]);
            r_ctrl      <= ~(r_mod[MOD_LCTRL]  | r_mod[MOD_RCTRL]);
            r_graph     <= ~(r_mod[MOD_LALT]   | r_mod[MOD_RALT]);
            r_key_valid <= w_accept;
        end
    end

    assign kb_col    = r_col;
    assign kb_shift  = r_shift;
    assign kb_ctrl   = r_ctrl;
    assign kb_graph  = r_graph;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Directed bench for einstein_kbd_matrix with a per-key behavioural model
// checked every cycle plus hand-computed literal expectations.
module tb_einstein_kbd_matrix;

    localparam int unsigned TICK = 100;

    logic clk_sys;
    logic reset;
    einstein_kbd_matrix_if bus ();

    einstein_kbd_matrix #(.TICK_CYCLES(TICK)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (bus.ps2_key),
        .kb_row    (bus.kb_row),
        .kb_col    (bus.kb_col),
        .kb_shift  (bus.kb_shift),
        .kb_ctrl   (bus.kb_ctrl),
        .kb_graph  (bus.kb_graph),
        .key_valid (bus.key_valid)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    bit   cmp_en = 0;
    logic tog = 1'b0;

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, required %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {7'b0, act}, {7'b0, exp});
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Behavioural model: one record per key position, plus modifier flags.
    bit          m_down [64];
    bit          m_p1   [64];
    bit          m_p2   [64];
    bit          m_mod  [6];
    int unsigned m_cnt;
    logic        m_tog;
    logic [7:0]  m_col;
    logic        m_shift, m_ctrl, m_graph, m_valid;

    bit          t_tick, t_ev, t_hit, t_ismod, d, p1, p2;
    int unsigned t_idx;
    logic [7:0]  t_col;

    function automatic void lookup(input logic [8:0] code, output bit hit, output bit ismod,
                                   output int unsigned idx);
        hit = 1'b1; ismod = 1'b0; idx = 0;
        case (code)
            9'h01C: idx = 2 * 8 + 1;
            9'h029: idx = 7 * 8 + 0;
            9'h05A: idx = 0 * 8 + 7;
            9'h175: idx = 5 * 8 + 3;
            9'h012: begin ismod = 1'b1; idx = 0; end
            9'h059: begin ismod = 1'b1; idx = 1; end
            9'h014: begin ismod = 1'b1; idx = 2; end
            9'h114: begin ismod = 1'b1; idx = 3; end
            9'h011: begin ismod = 1'b1; idx = 4; end
            9'h111: begin ismod = 1'b1; idx = 5; end
            default: hit = 1'b0;
        endcase
    endfunction

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) begin
                m_down[k] = 1'b0; m_p1[k] = 1'b0; m_p2[k] = 1'b0;
            end
            for (int k = 0; k < 6; k++) m_mod[k] = 1'b0;
            m_cnt = 0; m_tog = 1'b0;
            m_col = 8'hFF; m_shift = 1'b1; m_ctrl = 1'b1; m_graph = 1'b1; m_valid = 1'b0;
        end else begin
            t_col = 8'hFF;
            for (int k = 0; k < 64; k++)
                if (m_down[k] && !bus.kb_row[k / 8]) t_col[k % 8] = 1'b0;
            m_col   = t_col;
            m_shift = !(m_mod[0] || m_mod[1]);
            m_ctrl  = !(m_mod[2] || m_mod[3]);
            m_graph = !(m_mod[4] || m_mod[5]);
            t_tick  = (m_cnt == TICK - 1);
            m_cnt   = t_tick ? 0 : m_cnt + 1;
            t_ev    = (bus.ps2_key[10] != m_tog);
            m_tog   = bus.ps2_key[10];
            lookup(bus.ps2_key[8:0], t_hit, t_ismod, t_idx);
            m_valid = t_ev && t_hit;
            for (int k = 0; k < 64; k++) begin
                d = m_down[k]; p1 = m_p1[k]; p2 = m_p2[k];
                if (t_ev && t_hit && !t_ismod && t_idx == k) begin
                    if (bus.ps2_key[9]) begin d = 1'b1; p1 = 1'b0; p2 = 1'b0; end
                    else p1 = 1'b1;
                end else if (t_tick) begin
                    if (p2) begin d = 1'b0; p2 = 1'b0; p1 = 1'b0; end
                    else begin p2 = p1; p1 = 1'b0; end
                end
                m_down[k] = d; m_p1[k] = p1; m_p2[k] = p2;
            end
            if (t_ev && t_hit && t_ismod) m_mod[t_idx] = bus.ps2_key[9];
        end
    end

    always @(negedge clk_sys) begin
        if (cmp_en) begin
            check ("cyc_kb_col",    bus.kb_col,    m_col);
            check1("cyc_kb_shift",  bus.kb_shift,  m_shift);
            check1("cyc_kb_ctrl",   bus.kb_ctrl,   m_ctrl);
            check1("cyc_kb_graph",  bus.kb_graph,  m_graph);
            check1("cyc_key_valid", bus.key_valid, m_valid);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    task automatic send(input logic pressed, input logic [8:0] code);
        tog = ~tog;
        bus.ps2_key = {tog, pressed, code};
        step(1);
    endtask

    int cnt;

    initial begin
        reset = 1'b1;
        bus.ps2_key = '0;
        bus.kb_row = 8'hFF;
        step(3);
        cmp_en = 1'b1;
        check ("rst_kb_col", bus.kb_col, 8'hFF);
        check1("rst_kb_shift", bus.kb_shift, 1'b1);
        check1("rst_kb_ctrl", bus.kb_ctrl, 1'b1);
        check1("rst_kb_graph", bus.kb_graph, 1'b1);
        check1("rst_key_valid", bus.key_valid, 1'b0);
        reset = 1'b0;
        step(1);
        check1("idle_key_valid", bus.key_valid, 1'b0);

        // A on row 2 -> column 1
        bus.kb_row = 8'hFB;
        send(1'b1, 9'h01C);
        check1("a_key_valid", bus.key_valid, 1'b1);
        step(1);
        check("a_col_row2", bus.kb_col, 8'hFD);
        bus.kb_row = 8'hFF;
        step(1);
        check("a_col_norow", bus.kb_col, 8'hFF);
        bus.kb_row = 8'hFB;
        send(1'b0, 9'h01C);
        step(250);
        check("a_cleared", bus.kb_col, 8'hFF);

        // Short tap on Space: stretch length
        bus.kb_row = 8'h7F;
        send(1'b1, 9'h029);
        send(1'b0, 9'h029);
        step(1);
        cnt = 0;
        for (int i = 0; i < 300 && bus.kb_col[0] == 1'b0; i++) begin
            cnt++;
            step(1);
        end
        check_range("space_stretch_len", cnt, TICK, 2 * TICK);
        check("space_cleared", bus.kb_col, 8'hFF);

        // Modifiers
        send(1'b1, 9'h012);
        send(1'b1, 9'h059);
        send(1'b0, 9'h012);
        step(2);
        check1("shift_rsh_held", bus.kb_shift, 1'b0);
        send(1'b0, 9'h059);
        check1("shift_latency", bus.kb_shift, 1'b0);
        step(1);
        check1("shift_released", bus.kb_shift, 1'b1);
        send(1'b1, 9'h114);
        step(1);
        check1("rctrl_held", bus.kb_ctrl, 1'b0);
        send(1'b1, 9'h011);
        step(1);
        check1("lalt_held", bus.kb_graph, 1'b0);
        send(1'b0, 9'h114);
        send(1'b0, 9'h011);
        step(1);
        check1("ctrl_released", bus.kb_ctrl, 1'b1);
        check1("graph_released", bus.kb_graph, 1'b1);

        // Two rows selected; E0-extended vs plain code
        bus.kb_row = 8'hDE;
        send(1'b1, 9'h175);
        send(1'b1, 9'h05A);
        step(1);
        check("up_ret_col", bus.kb_col, 8'h77);
        send(1'b1, 9'h075);
        check1("unmapped_no_valid", bus.key_valid, 1'b0);
        step(1);
        check("unmapped_no_change", bus.kb_col, 8'h77);
        send(1'b0, 9'h175);
        send(1'b0, 9'h05A);
        step(250);
        check("up_ret_cleared", bus.kb_col, 8'hFF);

        // Release landing exactly on a tick while pend2 is set
        bus.kb_row = 8'hFB;
        send(1'b1, 9'h01C);
        send(1'b0, 9'h01C);
        step(1);
        for (int i = 0; i < 2 * TICK && m_cnt != 0; i++) step(1);
        check_range("race_wait_first_tick", int'(m_cnt), 0, 0);
        for (int i = 0; i < 2 * TICK && m_cnt != TICK - 1; i++) step(1);
        check_range("race_wait_pre_tick", int'(m_cnt), TICK - 1, TICK - 1);
        send(1'b0, 9'h01C);
        check1("race_key_valid", bus.key_valid, 1'b1);
        step(1);
        check("race_still_down", bus.kb_col, 8'hFD);
        step(99);
        check("race_down_before_tick", bus.kb_col, 8'hFD);
        step(1);
        check("race_cleared_after_tick", bus.kb_col, 8'hFF);

        // Reset mid-hold
        send(1'b1, 9'h01C);
        send(1'b1, 9'h012);
        step(1);
        check("hold_col", bus.kb_col, 8'hFD);
        check1("hold_shift", bus.kb_shift, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("midrst_col", bus.kb_col, 8'hFF);
        check1("midrst_shift", bus.kb_shift, 1'b1);
        tog = 1'b0;
        bus.ps2_key = '0;
        step(1);
        reset = 1'b0;
        step(3);
        check("postrst_col", bus.kb_col, 8'hFF);
        check1("postrst_shift", bus.kb_shift, 1'b1);

        // Toggle already high when reset releases counts as one event
        #1 reset = 1'b1;
        tog = 1'b1;
        bus.ps2_key = {1'b1, 1'b1, 9'h01C};
        step(1);
        reset = 1'b0;
        step(1);
        check1("tog1_key_valid", bus.key_valid, 1'b1);
        step(1);
        check("tog1_col", bus.kb_col, 8'hFD);
        check1("tog1_single_event", bus.key_valid, 1'b0);

        step(2);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
